bcd_timer: RTL
==============

BCD_TIMER -- requirements
Module: bcd_timer

Interface
REQ-001 Parameter MIN10_MAX, default 5, upper value of the minutes-tens digit (5 -> 59:59 max, 9 -> 99:59 max); legal range 1..9.
REQ-002 Parameter SEC_DIV, default 2, number of tick strobes per one-second count step; legal range >=1.
REQ-003 Parameter ADJ_DIV, default 1, number of tick strobes per adjust step; legal range >=1.
REQ-004 Parameter STOP_AT_ZERO, default 1, down-count behaviour at 00:00 (1 = hold, 0 = wrap to maximum).
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 tick  input  1  one-cycle base-rate strobe (e.g. 2 Hz); all timing derives from it.
REQ-008 pause  input  1  level; when high, digits and prescalers are frozen.
REQ-009 adj  input  1  level; when high, adjust mode replaces normal counting.
REQ-010 sel  input  1  adjust field select: 1 = seconds, 0 = minutes.
REQ-011 down  input  1  count direction in normal mode: 0 = up, 1 = down.
REQ-012 m10  output  4  minutes tens digit, BCD.
REQ-013 m1  output  4  minutes units digit, BCD.
REQ-014 s10  output  3  seconds tens digit, BCD 0..5.
REQ-015 s1  output  4  seconds units digit, BCD.
REQ-016 zero  output  1  combinational-free registered flag, high when all digits are 0.
REQ-017 wrap  output  1  one-cycle pulse on any full-display wrap (max->00:00 up, 00:00->max down).
REQ-018 done  output  1  one-cycle pulse when a down count steps from 00:01 to 00:00.

Function
REQ-019 Priority per cycle: rst > pause > adj > normal count.
REQ-020 Normal mode: sec prescaler increments on each tick; on reaching SEC_DIV-1 with tick it clears and the display steps one second in the direction given by down.
REQ-021 Up step: s1 0..9 carries into s10 0..5, carries into m1 0..9, carries into m10 0..MIN10_MAX; all-max steps to 00:00 and pulses wrap.
REQ-022 Down step: borrow chain mirrors REQ-021; 00:00 holds (no pulse) if STOP_AT_ZERO=1, else goes to MIN10_MAX9:59 and pulses wrap.
REQ-023 Adjust mode: adj prescaler counts ticks; every ADJ_DIV ticks the selected field (seconds or minutes pair) increments by one, wrapping within its own range with no carry to the other field; wrap and done do not pulse.
REQ-024 Sec prescaler clears on the cycle adj is high; adj prescaler clears on the cycle adj is low; the first count step after leaving adjust is a full SEC_DIV ticks later.
REQ-025 pause high freezes both prescalers; ticks arriving while paused are discarded.
REQ-026 down may change any cycle; it takes effect on the next step only.
REQ-027 Digits never hold non-BCD or out-of-range values; zero is updated in the same cycle as the digits.
REQ-028 done and wrap are registered, high for exactly one clk cycle, never together.

Reset
REQ-029 On rst high at a clk edge: all digits 0, both prescalers 0, zero = 1, wrap = 0, done = 0, regardless of pause/adj/tick.
REQ-030 rst mid-adjust or mid-prescale discards partial state; counting resumes SEC_DIV ticks after rst falls.

Structure
REQ-031 Package bcd_timer_pkg holds the BCD digit typedef, digit maxima (9, 5) and direction constants.
REQ-032 One sub-module bcd_pair: two-digit mod-N BCD counter with up/down enable, carry/borrow out, used for seconds and minutes.

Verification
REQ-033 Defaults, up, 120 ticks from reset -> 01:00, wrap never pulses.
REQ-034 Up from preset via adjust to 59:59, 2 ticks -> 00:00 with wrap pulse of one cycle.
REQ-035 down=1 from 00:02, STOP_AT_ZERO=1, 6 ticks -> 00:01, 00:00 with done pulse, then holds 00:00; with STOP_AT_ZERO=0 -> 59:59 and wrap pulse.
REQ-036 adj=1, sel=1 at 00:58, 3 ticks -> 00:01 with minutes unchanged; sel=0 at 59:xx, 1 tick -> 00:xx.
REQ-037 pause=1 for 10 ticks mid-count -> digits and prescaler unchanged; release -> counting resumes from the same prescaler phase.
REQ-038 rst asserted together with adj, pause and tick at 12:34 -> 00:00, zero=1 next cycle; MIN10_MAX=9 run reaches 99:59 then wraps.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the mm:ss BCD timer.
package bcd_timer_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t DIG_MAX = 4'd9;
   localparam digit_t TEN_MAX = 4'd5;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/bcd_timer_pair.sv
// Two-digit BCD counter, tens digit 0..HI_MAX, units 0..9, with up/down step.
module bcd_pair
   import bcd_timer_pkg::*;
#(
   parameter digit_t HI_MAX = TEN_MAX
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   up,
   input  logic   dn,
   output digit_t hi,
   output digit_t lo,
   output logic   at_max,
   output logic   at_min,
   output logic   nxt_zero
);

   digit_t hi_n;
   digit_t lo_n;

   assign at_max = (hi == HI_MAX) && (lo == DIG_MAX);
   assign at_min = (hi == '0) && (lo == '0);

   always_comb begin
      hi_n = hi;
      lo_n = lo;
      if (up) begin
         if (at_max) begin
            hi_n = '0;
            lo_n = '0;
         end else if (lo == DIG_MAX) begin
            lo_n = '0;
            hi_n = hi + 4'd1;
         end else begin
            lo_n = lo + 4'd1;
         end
      end else if (dn) begin
         if (at_min) begin
            hi_n = HI_MAX;
            lo_n = DIG_MAX;
         end else if (lo == '0) begin
            lo_n = DIG_MAX;
            hi_n = hi - 4'd1;
         end else begin
            lo_n = lo - 4'd1;
         end
      end
   end

   // lets the parent register its zero flag alongside the digits
   assign nxt_zero = (hi_n == '0) && (lo_n == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else begin
         hi <= hi_n;
         lo <= lo_n;
      end
   end

endmodule

// File: rtl/bcd_timer.sv
// mm:ss BCD up/down timer with tick prescaling, pause and field adjust.
module bcd_timer
   import bcd_timer_pkg::*;
#(
   parameter int MIN10_MAX    = 5,
   parameter int SEC_DIV      = 2,
   parameter int ADJ_DIV      = 1,
   parameter bit STOP_AT_ZERO = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       pause,
   input  logic       adj,
   input  logic       sel,
   input  logic       down,
   output logic [3:0] m10,
   output logic [3:0] m1,
   output logic [2:0] s10,
   output logic [3:0] s1,
   output logic       zero,
   output logic       wrap,
   output logic       done
);

   localparam int SW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
   localparam int AW = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
   localparam logic [SW-1:0] SEC_LAST = SW'(SEC_DIV - 1);
   localparam logic [AW-1:0] ADJ_LAST = AW'(ADJ_DIV - 1);

   logic [SW-1:0] sec_pre;
   logic [AW-1:0] adj_pre;
   logic   run, adjust, sec_step, adj_step;
   logic   hold, up_step, dn_step, one;
   logic   s_up, s_dn, m_up, m_dn;
   logic   s_max, s_min, s_nz, m_max, m_min, m_nz;
   logic   wrap_n, done_n;
   digit_t s10_d, s1_d, m10_d, m1_d;

   assign run      = !pause && !adj;
   assign adjust   = !pause && adj;
   assign sec_step = run && tick && (sec_pre == SEC_LAST);
   assign adj_step = adjust && tick && (adj_pre == ADJ_LAST);

   assign hold    = STOP_AT_ZERO && s_min && m_min;
   assign up_step = sec_step && (down == DIR_UP);
   assign dn_step = sec_step && (down == DIR_DN) && !hold;

   // adjust steps one field only, never carrying into the other
   assign s_up = up_step || (adj_step && sel);
   assign s_dn = dn_step;
   assign m_up = (up_step && s_max) || (adj_step && !sel);
   assign m_dn = dn_step && s_min;

   assign one    = m_min && (s10_d == '0) && (s1_d == 4'd1);
   assign wrap_n = (up_step && s_max && m_max)
                || (dn_step && s_min && m_min);
   assign done_n = dn_step && one;

   bcd_pair #(.HI_MAX(TEN_MAX)) u_sec (
      .clk      (clk),
      .rst      (rst),
      .up       (s_up),
      .dn       (s_dn),
      .hi       (s10_d),
      .lo       (s1_d),
      .at_max   (s_max),
      .at_min   (s_min),
      .nxt_zero (s_nz)
   );

   bcd_pair #(.HI_MAX(digit_t'(MIN10_MAX))) u_min (
      .clk      (clk),
      .rst      (rst),
      .up       (m_up),
      .dn       (m_dn),
      .hi       (m10_d),
      .lo       (m1_d),
      .at_max   (m_max),
      .at_min   (m_min),
      .nxt_zero (m_nz)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sec_pre <= '0;
         adj_pre <= '0;
         zero    <= 1'b1;
         wrap    <= 1'b0;
         done    <= 1'b0;
      end else begin
         zero <= s_nz && m_nz;
         wrap <= wrap_n;
         done <= done_n;
         if (adjust) begin
            sec_pre <= '0;
            if (tick)
               adj_pre <= adj_step ? '0 : adj_pre + 1'b1;
         end else if (run) begin
            adj_pre <= '0;
            if (tick)
               sec_pre <= sec_step ? '0 : sec_pre + 1'b1;
         end
      end
   end

   assign m10 = m10_d;
   assign m1  = m1_d;
   assign s10 = s10_d[2:0];
   assign s1  = s1_d;

endmodule
